// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX serializer among NREQ requesters.
// Optional WAIT watchdog enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int unsigned NREQ           = 4,
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                     tx_clk,
    input  logic                     tx_rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*WIDTH-1:0]    req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          req_done,
    output logic                     ser_en,
    output logic [WIDTH-1:0]         ser_data,
    input  logic                     ser_done,
    output logic                     busy,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     timeout_err
);

    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned GW  = $clog2(GAP_CYCLES + 1);

    // Elaboration-time parameter sanity checks
    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("uart_tx_arbiter: NREQ must be 2..8");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
        $error("uart_tx_arbiter: GAP_CYCLES must be >= 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("uart_tx_arbiter: TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_GAP
    } state_t;

    state_t             state, state_nxt;
    logic [IDW-1:0]     rr_ptr, rr_nxt;
    logic [IDW-1:0]     grant_nxt;
    logic [WIDTH-1:0]   ser_data_nxt;
    logic [NREQ-1:0]    ready_nxt, done_nxt;
    logic               ser_en_nxt, busy_nxt;
    logic [GW-1:0]      gap_cnt, gap_nxt;
    logic               settled;
    logic               win_found;
    logic [IDW-1:0]     win_id;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]      to_cnt, to_nxt;
    logic               to_err_nxt;
`endif

    function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] id);
        return {{(NREQ-1){1'b0}}, 1'b1} << id;
    endfunction

    // First requester found scanning from rr_ptr upwards, modulo NREQ
    always_comb begin : rr_scan
        int unsigned idx;
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(rr_ptr) + k) % NREQ;
            if (!win_found && req_valid[IDW'(idx)]) begin
                win_found = 1'b1;
                win_id    = IDW'(idx);
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt    = state;
        rr_nxt       = rr_ptr;
        grant_nxt    = grant_id;
        ser_data_nxt = ser_data;
        ready_nxt    = '0;
        done_nxt     = '0;
        ser_en_nxt   = 1'b0;
        gap_nxt      = gap_cnt;
`ifdef UART_TX_ARB_TIMEOUT_EN
        to_nxt       = to_cnt;
        to_err_nxt   = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (settled && win_found) begin
                    grant_nxt = win_id;
                    ready_nxt = onehot(win_id);
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (req_valid[grant_id]) begin
                    ser_data_nxt = req_data[32'(grant_id)*WIDTH +: WIDTH];
                    ser_en_nxt   = 1'b1;
                    state_nxt    = S_START;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_START: begin
                rr_nxt    = (32'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;
                state_nxt = S_WAIT;
`ifdef UART_TX_ARB_TIMEOUT_EN
                to_nxt    = '0;
`endif
            end
            S_WAIT: begin
                if (ser_done) begin
                    done_nxt  = onehot(grant_id);
                    gap_nxt   = '0;
                    state_nxt = S_GAP;
                end
`ifdef UART_TX_ARB_TIMEOUT_EN
                else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    to_err_nxt = 1'b1;
                    gap_nxt    = '0;
                    state_nxt  = S_GAP;
                end else begin
                    to_nxt = to_cnt + 1'b1;
                end
`endif
            end
            S_GAP: begin
                if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                    state_nxt = S_IDLE;
                end else begin
                    gap_nxt = gap_cnt + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        busy_nxt = (state_nxt != S_IDLE);
    end

    // State and registered outputs; settled holds off arbitration for one cycle after reset
    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            ser_data  <= '0;
            req_ready <= '0;
            req_done  <= '0;
            ser_en    <= 1'b0;
            busy      <= 1'b0;
            gap_cnt   <= '0;
            settled   <= 1'b0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_nxt;
            grant_id  <= grant_nxt;
            ser_data  <= ser_data_nxt;
            req_ready <= ready_nxt;
            req_done  <= done_nxt;
            ser_en    <= ser_en_nxt;
            busy      <= busy_nxt;
            gap_cnt   <= gap_nxt;
            settled   <= 1'b1;
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            to_cnt      <= to_nxt;
            timeout_err <= to_err_nxt;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule
